// File: rtl/rfile_pkg.sv
// Shared register-file constants and writeback stage state encoding.
// Pure declarations; no logic or latency.
package rfile_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int NUM_REGS   = 1 << REG_ADDR_W;

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;
endpackage

// File: rtl/rfile_wb_arbiter_if.sv
// Writeback requester bundle plus register-file write port; master = requesters, slave = arbiter.
// Carries valid/ready per requester and the hold/freeze input.
interface rfile_wb_arbiter_if #(
    parameter int NREQ   = 3,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic [NREQ-1:0]        req_valid;
    logic [NREQ*ADDR_W-1:0] req_reg;
    logic [NREQ*DATA_W-1:0] req_data;
    logic [NREQ-1:0]        req_ready;
    logic                   wb_hold;
    logic                   wr_en;
    logic [ADDR_W-1:0]      wr_reg;
    logic [DATA_W-1:0]      wr_data;
    logic [(1<<ADDR_W)-1:0] pending_mask;

    modport master (
        output req_valid, req_reg, req_data, wb_hold,
        input  req_ready, wr_en, wr_reg, wr_data, pending_mask
    );

    modport slave (
        input  req_valid, req_reg, req_data, wb_hold,
        output req_ready, wr_en, wr_reg, wr_data, pending_mask
    );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, modulo NREQ.
// Zero latency; grant is one-hot or all-zero when nothing requests.
module rr_arbiter #(
    parameter  int NREQ  = 3,
    localparam int PTR_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic [NREQ-1:0]  grant
);
    logic [PTR_W:0]   pos;
    logic [PTR_W-1:0] idx;
    logic             found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        pos   = '0;
        idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            pos = {1'b0, ptr} + (PTR_W+1)'(k);
            if (pos >= (PTR_W+1)'(NREQ)) begin
                pos = pos - (PTR_W+1)'(NREQ);
            end
            idx = pos[PTR_W-1:0];
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end
endmodule

// File: rtl/rfile_wb_arbiter.sv
// Round-robin share of the register-file write port; accept at edge N -> wr_en in cycle N+1, one write/cycle.
// wb_hold freezes grants and the stage; define RFILE_R0_DISCARD_EN to ack-and-drop writes to register 0.
module rfile_wb_arbiter
    import rfile_pkg::*;
#(
    parameter int NREQ   = 3,
    parameter int ADDR_W = REG_ADDR_W,
    parameter int DATA_W = REG_DATA_W
) (
    input logic              clk,
    input logic              rst,
    rfile_wb_arbiter_if.slave bus
);
    localparam int PTR_W = $clog2(NREQ);
    localparam int MASK_W = 1 << ADDR_W;

`ifdef RFILE_R0_DISCARD_EN
    localparam bit R0_DISCARD = 1'b1;
`else
    localparam bit R0_DISCARD = 1'b0;
`endif

    logic [0:0]        state;
    logic [PTR_W-1:0]  ptr;
    logic [PTR_W-1:0]  sel;
    logic [PTR_W-1:0]  ptr_next;
    logic [NREQ-1:0]   grant;
    logic              grant_en;
    logic              xfer;
    logic              load;
    logic [ADDR_W-1:0] sel_reg;
    logic [DATA_W-1:0] sel_data;
    logic [ADDR_W-1:0] stage_reg;
    logic [DATA_W-1:0] stage_data;
    logic              stage_full;

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req   (bus.req_valid),
        .ptr   (ptr),
        .grant (grant)
    );

    // A FULL stage drains in the same cycle it is refilled, so only hold/reset block grants.
    assign grant_en      = !rst && !bus.wb_hold;
    assign bus.req_ready = grant_en ? grant : '0;
    assign xfer          = grant_en && (grant != '0);

    always_comb begin
        sel      = '0;
        sel_reg  = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel      = PTR_W'(i);
                sel_reg  = bus.req_reg[i*ADDR_W +: ADDR_W];
                sel_data = bus.req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign load     = xfer && !(R0_DISCARD && (sel_reg == '0));
    assign ptr_next = (sel == PTR_W'(NREQ-1)) ? '0 : sel + PTR_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_EMPTY;
            ptr        <= '0;
            stage_reg  <= '0;
            stage_data <= '0;
        end else if (!bus.wb_hold) begin
            if (xfer) begin
                ptr <= ptr_next;
            end
            if (load) begin
                state      <= ST_FULL;
                stage_reg  <= sel_reg;
                stage_data <= sel_data;
            end else begin
                state <= ST_EMPTY;
            end
        end
    end

    // Gating with rst keeps a stage caught by reset from ever reaching the register file.
    assign stage_full       = (state == ST_FULL) && !rst;
    assign bus.wr_en        = stage_full && !bus.wb_hold;
    assign bus.wr_reg       = stage_reg;
    assign bus.wr_data      = stage_data;
    assign bus.pending_mask = stage_full ? (MASK_W'(1) << stage_reg) : '0;
endmodule
